// File: rtl/btn_conditioner.sv
// Push-button front end: 12 identical channels, each synchronised, debounced and
// turned into a one-cycle press pulse. Optional stuck-button flags: BTN_STUCK_EN.

module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
`ifdef BTN_STUCK_EN
  ,
  parameter int STUCK_CYCLES    = 500000000,
  parameter int STUCK_W         = 29
`endif
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_enable,
  input  logic i_raw,
  output logic o_pulse
`ifdef BTN_STUCK_EN
  ,
  output logic o_stuck
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  logic             w_stable_nxt;
  logic             w_pulse_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // NOTE: the synchroniser flops are reset too, so a button held through reset
  // is seen as a fresh 0->1 transition and produces exactly one press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so r_sync2 takes the old r_sync1 value;
      // blocking here would collapse the two stages into one.
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = r_cnt;
    w_pulse_nxt  = 1'b0;
    if (i_enable) begin
      if (r_sync2 == r_stable) begin
        w_cnt_nxt = '0;
      end else if (r_cnt >= CNT_LAST) begin
        w_stable_nxt = r_sync2;
        w_cnt_nxt    = '0;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
      w_pulse_nxt = w_stable_nxt & ~r_stable;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_stable <= w_stable_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pulse  <= w_pulse_nxt;
    end
  end

  assign o_pulse = r_pulse;

`ifdef BTN_STUCK_EN
  localparam logic [STUCK_W-1:0] SCNT_MAX = STUCK_W'(STUCK_CYCLES);

  logic [STUCK_W-1:0] r_scnt;
  logic               r_stuck;
  logic [STUCK_W-1:0] w_scnt_nxt;
  logic               w_stuck_nxt;

  // Counts enabled cycles spent pressed; cleared on the edge the release is accepted.
  always_comb begin
    w_scnt_nxt  = r_scnt;
    w_stuck_nxt = r_stuck;
    if (!w_stable_nxt) begin
      w_scnt_nxt  = '0;
      w_stuck_nxt = 1'b0;
    end else if (i_enable && r_stable && (r_scnt != SCNT_MAX)) begin
      w_scnt_nxt = r_scnt + STUCK_W'(1);
      if (r_scnt == SCNT_MAX - STUCK_W'(1)) begin
        w_stuck_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_scnt  <= '0;
      r_stuck <= 1'b0;
    end else begin
      r_scnt  <= w_scnt_nxt;
      r_stuck <= w_stuck_nxt;
    end
  end

  assign o_stuck = r_stuck;
`endif

endmodule

module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
`ifdef BTN_STUCK_EN
  ,
  parameter int STUCK_CYCLES    = 500000000,
  parameter int STUCK_W         = 29
`endif
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [4:0] raw_btncar,
  input  logic [4:0] raw_btnout,
  input  logic       raw_open,
  input  logic       raw_shut,
  output logic [4:0] btncar,
  output logic [4:0] btnout,
  output logic       open,
  output logic       shut
`ifdef BTN_STUCK_EN
  ,
  output logic [11:0] stuck
`endif
);

  localparam int NUM_CH = 12;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 2");
  end
  if ((64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("btn_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
`ifdef BTN_STUCK_EN
  if ((64'(1) << STUCK_W) <= 64'(STUCK_CYCLES)) begin : g_bad_stuck_w
    $error("btn_conditioner: STUCK_W too narrow for STUCK_CYCLES");
  end
`endif

  // Channel order: 0-4 car, 5-9 hall, 10 door-open, 11 door-shut.
  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_pulse;
`ifdef BTN_STUCK_EN
  logic [NUM_CH-1:0] w_stuck;
`endif

  assign w_raw = {raw_shut, raw_open, raw_btnout, raw_btncar};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
`ifdef BTN_STUCK_EN
      ,
      .STUCK_CYCLES    (STUCK_CYCLES),
      .STUCK_W         (STUCK_W)
`endif
    ) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .i_enable (enable),
      .i_raw    (w_raw[i]),
      .o_pulse  (w_pulse[i])
`ifdef BTN_STUCK_EN
      ,
      .o_stuck  (w_stuck[i])
`endif
    );
  end

  assign btncar = w_pulse[4:0];
  assign btnout = w_pulse[9:5];
  assign open   = w_pulse[10];
  assign shut   = w_pulse[11];
`ifdef BTN_STUCK_EN
  assign stuck  = w_stuck;
`endif

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

- Front end for the elevator controller: conditions the raw board push-buttons before they reach the controller.
  - Raw inputs: 5 car buttons, 5 hall buttons, door-open, door-shut.
- Each raw input is synchronised, debounced, and converted to a single-cycle press pulse.
- The pulses drive the controller's btncar, btnout, open and shut inputs directly.
- The controller does no filtering of its own, so every bounce reaching it would register a request. This block guarantees exactly one pulse per physical press.

## Interface
- DEBOUNCE_CYCLES, default 1000000: consecutive cycles a new input level must hold before it is accepted (10 ms at 100 MHz); must be ≥ 2.
- CNT_W, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- STUCK_CYCLES, default 500000000: held-press length that flags a stuck button (BTN_STUCK_EN only).
- STUCK_W, default 29: stuck counter width; must satisfy 2^STUCK_W > STUCK_CYCLES.
- clk  in  1  system clock; single clock domain.
- resetn  in  1  reset, asynchronous, active-low.
- enable  in  1  global run enable, shared with the rest of the controller.
- raw_btncar  in  5  asynchronous car-panel buttons; bit i = floor i+1.
- raw_btnout  in  5  asynchronous hall buttons; bit i = floor i+1.
- raw_open  in  1  asynchronous door-open button.
- raw_shut  in  1  asynchronous door-shut button.
- btncar  out  5  one-cycle press pulses, one per car button.
- btnout  out  5  one-cycle press pulses, one per hall button.
- open  out  1  one-cycle press pulse, door-open.
- shut  out  1  one-cycle press pulse, door-shut.
- stuck  out  12  per-channel stuck flags (BTN_STUCK_EN only).

## Operation
- Channel index map: 0–4 = btncar[0..4], 5–9 = btnout[0..4], 10 = open, 11 = shut.
- All 12 channels are identical and independent.
- Per-channel state:
  - sync1, sync2: 2-flop synchroniser. It always runs, even when enable = 0.
  - stable: the accepted input level.
  - cnt[CNT_W-1:0]: debounce counter.
  - pulse: registered output.
- Behaviour with enable = 1, each clock edge:
  - If sync2 == stable: cnt ← 0 (any agreeing cycle restarts the count).
  - If sync2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - If sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable ← sync2 and cnt ← 0.
  - pulse ← 1 only on the edge where stable changes 0→1; otherwise pulse ← 0.
  - A release (stable 1→0) produces no pulse.
- Behaviour with enable = 0:
  - cnt, stable and the stuck counters hold their values.
  - pulse ← 0.
  - Debouncing resumes from the held cnt when enable returns to 1.
- Multiple channels may pulse in the same cycle; there is no arbitration.
- Reset: every register clears to 0, so every output is 0.
  - A button held through reset is accepted as a new press DEBOUNCE_CYCLES+2 edges after resetn deasserts.
- Reset mid-debounce discards the partial count.

## Timing
- Raw input high before edge 1, counting edges from the first edge that samples it high:
  - sync1 = 1 after edge 1.
  - sync2 = 1 after edge 2.
  - cnt = j after edge 2+j, for j < DEBOUNCE_CYCLES.
  - stable = 1 and pulse = 1 after edge DEBOUNCE_CYCLES+2.
  - pulse = 0 after edge DEBOUNCE_CYCLES+3.
- Press latency is therefore DEBOUNCE_CYCLES+2 cycles.
- Each pulse is exactly one cycle wide.
- A glitch shorter than DEBOUNCE_CYCLES cycles (as seen at sync2) never changes stable.
- Release uses the same filter: a new press is possible only after the release has held for DEBOUNCE_CYCLES cycles.
- Counter saturation is impossible: cnt never exceeds DEBOUNCE_CYCLES-1.

## Configuration
- Macro: BTN_STUCK_EN.
- Defined:
  - Each channel has a stuck counter scnt[STUCK_W-1:0], which increments while stable = 1 and enable = 1.
  - It saturates at STUCK_CYCLES.
  - stuck[i] ← 1 on the edge where scnt reaches STUCK_CYCLES.
  - stuck[i] stays 1 until stable goes 0; then scnt and stuck[i] clear on that edge.
  - stuck has no effect on pulse generation.
- Undefined: the stuck port, the stuck counters and the STUCK_* parameters are absent.

## Test plan
- Clean press (DEBOUNCE_CYCLES = 4): raw_btncar[2] 0→1 and held. Required: btncar = 5'b00100 for exactly one cycle, after edge 6; btncar = 0 after edge 7; nothing further while held.
- Bounce (DEBOUNCE_CYCLES = 4): raw_open toggles 1,0,1,1,0 on successive cycles, then settles high. Required: open pulses once, 6 edges after the last 0→1 transition seen at the input.
- Glitch: raw_shut high for 3 cycles, then low. Required: shut never asserts and stable stays 0.
- Simultaneous presses: raw_btnout[0] and raw_btnout[4] rise on the same cycle. Required: btnout = 5'b10001 for one cycle.
- Enable and reset:
  - enable drops for 10 cycles after cnt = 2, then returns. Required: pulse appears 10 cycles later than in the clean-press case.
  - resetn asserted mid-count. Required: all outputs 0 immediately (asynchronously), and cnt restarts from 0.
- With BTN_STUCK_EN, STUCK_CYCLES = 8: hold raw_btncar[0]. Required: stuck[0] = 1 eight enabled cycles after the press pulse; stuck[0] = 0 on the edge where stable drops after release.
